// File: rtl/imm4_alloc_pkg.sv
// Shared sizing and slot-tag helpers for the 4-wide immediate-store allocator.
// A slot tag is {group, lane}: the upper WIDTH_ADDR-2 bits pick the group, the low 2 bits the lane.
package imm4_alloc_pkg;

    localparam int DFLT_WIDTH_ADDR = 5;
    localparam int LANES           = 4;
    localparam int LANE_W          = 2;

    function automatic int size_of(input int width_addr);
        return 2 ** width_addr;
    endfunction

    function automatic int groups_of(input int width_addr);
        return (2 ** width_addr) / LANES;
    endfunction

    function automatic int gidx_w_of(input int width_addr);
        return width_addr - LANE_W;
    endfunction

    // One extra bit over the group index so the count can reach GROUPS itself.
    function automatic int cnt_w_of(input int width_addr);
        return width_addr - 1;
    endfunction

endpackage

// File: rtl/imm4_alloc_pick.sv
// Lowest-index priority encoder over the free-group vector.
// Produces a one-hot grant, its binary index, and an any-free flag.
module imm4_alloc_pick #(
    parameter int GROUPS = 8,
    parameter int GIDX_W = 3
) (
    input  logic [GROUPS-1:0] i_free,
    output logic [GROUPS-1:0] o_grant,
    output logic [GIDX_W-1:0] o_idx,
    output logic              o_any
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int g = 0; g < GROUPS; g++) begin
            if (i_free[g] && !o_any) begin
                o_grant[g] = 1'b1;
                o_idx      = GIDX_W'(g);
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/imm4_alloc.sv
// Group allocator and write-port driver for the 4-read/4-write immediate store.
// Optional feature: define IMM4_ALLOC_FLUSH_EN to add i_flush (clears all occupancy, blocks o_we).
module imm4_alloc
    import imm4_alloc_pkg::*;
#(
    parameter int WIDTH_ADDR = DFLT_WIDTH_ADDR,
    localparam int SIZE      = size_of(WIDTH_ADDR),
    localparam int GROUPS    = groups_of(WIDTH_ADDR),
    localparam int GIDX_W    = gidx_w_of(WIDTH_ADDR),
    localparam int CNT_W     = cnt_w_of(WIDTH_ADDR)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_alloc_req,
    input  logic [LANES-1:0]      i_alloc_mask,
    output logic                  o_alloc_ready,
    output logic                  o_we,
    output logic [GROUPS-1:0]     o_waddr,
    output logic [GIDX_W-1:0]     o_gaddr,
    input  logic [LANES-1:0]      i_rel_en,
    input  logic [WIDTH_ADDR-1:0] i_rel_addr0,
    input  logic [WIDTH_ADDR-1:0] i_rel_addr1,
    input  logic [WIDTH_ADDR-1:0] i_rel_addr2,
    input  logic [WIDTH_ADDR-1:0] i_rel_addr3,
`ifdef IMM4_ALLOC_FLUSH_EN
    input  logic                  i_flush,
`endif
    output logic [CNT_W-1:0]      o_free_cnt
);

    logic [SIZE-1:0]       r_busy;
    logic [CNT_W-1:0]      r_free_cnt;
    logic                  r_ready;

    logic [SIZE-1:0]       w_busy_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [GROUPS-1:0]     w_group_free;
    logic [GROUPS-1:0]     w_grant;
    logic [GIDX_W-1:0]     w_gidx;
    logic                  w_any;
    logic                  w_flush;
    logic                  w_we;
    logic [WIDTH_ADDR-1:0] w_rel_addr [LANES];

`ifdef IMM4_ALLOC_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    assign w_rel_addr[0] = i_rel_addr0;
    assign w_rel_addr[1] = i_rel_addr1;
    assign w_rel_addr[2] = i_rel_addr2;
    assign w_rel_addr[3] = i_rel_addr3;

    always_comb begin
        w_group_free = '0;
        for (int g = 0; g < GROUPS; g++) begin
            w_group_free[g] = ~|r_busy[LANES*g +: LANES];
        end
    end

    imm4_alloc_pick #(
        .GROUPS (GROUPS),
        .GIDX_W (GIDX_W)
    ) u_pick (
        .i_free  (w_group_free),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_any)
    );

    // A flush cycle never writes the store, so the granted group stays free.
    assign w_we    = i_alloc_req & r_ready & w_any & (|i_alloc_mask) & ~w_flush;
    assign o_we    = w_we;
    assign o_waddr = w_we ? w_grant : '0;
    assign o_gaddr = w_we ? w_gidx  : '0;

    // Releases clear first, then the grant sets its masked lanes; the granted group has no busy bits to clash with.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_flush) begin
            w_busy_nxt = '0;
        end else begin
            for (int n = 0; n < LANES; n++) begin
                if (i_rel_en[n]) begin
                    w_busy_nxt[w_rel_addr[n]] = 1'b0;
                end
            end
            for (int n = 0; n < LANES; n++) begin
                if (w_we && i_alloc_mask[n]) begin
                    w_busy_nxt[{w_gidx, LANE_W'(n)}] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int g = 0; g < GROUPS; g++) begin
            w_cnt_nxt = w_cnt_nxt + CNT_W'(~|w_busy_nxt[LANES*g +: LANES]);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy     <= '0;
            r_free_cnt <= CNT_W'(GROUPS);
            r_ready    <= 1'b1;
        end else begin
            r_busy     <= w_busy_nxt;
            r_free_cnt <= w_cnt_nxt;
            r_ready    <= (w_cnt_nxt != '0);
        end
    end

    assign o_free_cnt    = r_free_cnt;
    assign o_alloc_ready = r_ready;

endmodule

// File: tb/tb_imm4_alloc.sv
// Self-checking bench for imm4_alloc: directed scenarios plus random traffic against a slot-occupancy model.
// Define IMM4_ALLOC_FLUSH_EN for both RTL and bench to exercise the flush scenario.
module tb_imm4_alloc;

    localparam int WA     = 5;
    localparam int SIZE   = 32;
    localparam int GROUPS = 8;

    logic          clk;
    logic          rst;
    logic          alloc_req;
    logic [3:0]    alloc_mask;
    logic          alloc_ready;
    logic          we;
    logic [7:0]    waddr;
    logic [2:0]    gaddr;
    logic [3:0]    rel_en;
    logic [WA-1:0] rel_addr0, rel_addr1, rel_addr2, rel_addr3;
    logic [3:0]    free_cnt;
`ifdef IMM4_ALLOC_FLUSH_EN
    logic          flush;
`endif

    imm4_alloc #(.WIDTH_ADDR(WA)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_alloc_req   (alloc_req),
        .i_alloc_mask  (alloc_mask),
        .o_alloc_ready (alloc_ready),
        .o_we          (we),
        .o_waddr       (waddr),
        .o_gaddr       (gaddr),
        .i_rel_en      (rel_en),
        .i_rel_addr0   (rel_addr0),
        .i_rel_addr1   (rel_addr1),
        .i_rel_addr2   (rel_addr2),
        .i_rel_addr3   (rel_addr3),
`ifdef IMM4_ALLOC_FLUSH_EN
        .i_flush       (flush),
`endif
        .o_free_cnt    (free_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one occupancy bit per slot, plus the inputs applied this cycle.
    bit occ [SIZE];
    bit flush_v;
    bit exp_we;
    int exp_g;
    int rel_a [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit group_free(input int g);
        return !(occ[4*g] || occ[4*g+1] || occ[4*g+2] || occ[4*g+3]);
    endfunction

    function automatic int m_free_cnt();
        int c = 0;
        for (int g = 0; g < GROUPS; g++) if (group_free(g)) c++;
        return c;
    endfunction

    function automatic int m_lowest();
        for (int g = 0; g < GROUPS; g++) if (group_free(g)) return g;
        return -1;
    endfunction

    // Apply inputs mid-cycle and compare all outputs against the model's current state.
    task automatic drive(input bit req, input bit [3:0] mask, input bit [3:0] ren,
                         input int a0, input int a1, input int a2, input int a3);
        alloc_req  = req;
        alloc_mask = mask;
        rel_en     = ren;
        rel_a[0] = a0; rel_a[1] = a1; rel_a[2] = a2; rel_a[3] = a3;
        rel_addr0  = WA'(a0);
        rel_addr1  = WA'(a1);
        rel_addr2  = WA'(a2);
        rel_addr3  = WA'(a3);
`ifdef IMM4_ALLOC_FLUSH_EN
        flush = flush_v;
`endif
        #2;
        exp_g  = m_lowest();
        exp_we = req && (exp_g >= 0) && (mask != 4'b0) && !flush_v;
        check("we", 32'(we), 32'(exp_we));
        check("waddr", 32'(waddr), exp_we ? (32'd1 << exp_g) : 32'd0);
        check("gaddr", 32'(gaddr), exp_we ? 32'(exp_g) : 32'd0);
        check("free_cnt", 32'(free_cnt), 32'(m_free_cnt()));
        check("ready", 32'(alloc_ready), 32'(m_free_cnt() != 0));
    endtask

    task automatic finish_cycle();
        if (rst || flush_v) begin
            for (int s = 0; s < SIZE; s++) occ[s] = 1'b0;
        end else begin
            for (int p = 0; p < 4; p++) if (rel_en[p]) occ[rel_a[p]] = 1'b0;
            if (exp_we) for (int l = 0; l < 4; l++) if (alloc_mask[l]) occ[4*exp_g+l] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        flush_v = 1'b0;
        alloc_req = 1'b0; alloc_mask = 4'b0; rel_en = 4'b0;
        rel_addr0 = '0; rel_addr1 = '0; rel_addr2 = '0; rel_addr3 = '0;
`ifdef IMM4_ALLOC_FLUSH_EN
        flush = 1'b0;
`endif
        @(posedge clk); #1;
        finish_cycle();
        rst = 1'b0;

        // Reset state
        #2;
        check("rst_free_cnt", 32'(free_cnt), 32'd8);
        check("rst_ready", 32'(alloc_ready), 32'd1);
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", 32'(waddr), 32'd0);

        // Fill all eight groups in order
        for (int i = 0; i < 8; i++) begin
            drive(1, 4'hf, 4'h0, 0, 0, 0, 0);
            check("fill_waddr", 32'(waddr), 32'd1 << i);
            check("fill_gaddr", 32'(gaddr), 32'(i));
            finish_cycle();
        end
        drive(1, 4'hf, 4'h0, 0, 0, 0, 0);
        check("full_cnt", 32'(free_cnt), 32'd0);
        check("full_ready", 32'(alloc_ready), 32'd0);
        check("full_we", 32'(we), 32'd0);
        finish_cycle();

        // Release group 3 on all four ports at once
        drive(0, 4'h0, 4'hf, 12, 13, 14, 15);
        finish_cycle();
        drive(1, 4'hf, 4'h0, 0, 0, 0, 0);
        check("refill_cnt", 32'(free_cnt), 32'd1);
        check("refill_waddr", 32'(waddr), 32'h08);
        finish_cycle();

        // Drain everything
        for (int k = 0; k < 8; k++) begin
            drive(0, 4'h0, 4'hf, 4*k, 4*k+1, 4*k+2, 4*k+3);
            finish_cycle();
        end

        // Partial mask: group stays busy until both masked lanes are released
        drive(1, 4'b0101, 4'h0, 0, 0, 0, 0);
        check("part_cnt0", 32'(free_cnt), 32'd8);
        check("part_waddr", 32'(waddr), 32'h01);
        finish_cycle();
        drive(0, 4'h0, 4'b0001, 0, 0, 0, 0);
        finish_cycle();
        drive(0, 4'h0, 4'b0100, 2, 0, 2, 0);
        check("part_cnt7", 32'(free_cnt), 32'd7);
        finish_cycle();
        drive(0, 4'h0, 4'h0, 0, 0, 0, 0);
        check("part_cnt8", 32'(free_cnt), 32'd8);
        finish_cycle();

        // Alloc empty mask: no grant
        drive(1, 4'h0, 4'h0, 0, 0, 0, 0);
        check("nomask_we", 32'(we), 32'd0);
        finish_cycle();

        // Same-cycle release of group 0's last slot and a new request
        drive(1, 4'b0001, 4'h0, 0, 0, 0, 0);
        finish_cycle();
        drive(1, 4'hf, 4'b0001, 0, 0, 0, 0);
        check("same_waddr", 32'(waddr), 32'h02);
        finish_cycle();
        drive(1, 4'hf, 4'h0, 0, 0, 0, 0);
        check("next_waddr", 32'(waddr), 32'h01);
        finish_cycle();

        // Release a free slot and a duplicated busy slot
        drive(0, 4'h0, 4'b0111, 9, 4, 4, 0);
        finish_cycle();
        drive(0, 4'h0, 4'h0, 0, 0, 0, 0);
        check("dup_cnt", 32'(free_cnt), 32'd6);
        finish_cycle();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
                  $urandom_range(0, SIZE-1), $urandom_range(0, SIZE-1),
                  $urandom_range(0, SIZE-1), $urandom_range(0, SIZE-1));
            finish_cycle();
        end

        // Reset mid-operation with releases pending
        rst = 1'b1;
        drive(0, 4'h0, 4'hf, 0, 5, 10, 20);
        finish_cycle();
        rst = 1'b0;
        drive(0, 4'h0, 4'h0, 0, 0, 0, 0);
        check("midrst_cnt", 32'(free_cnt), 32'd8);
        finish_cycle();

`ifdef IMM4_ALLOC_FLUSH_EN
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'hf, 4'h0, 0, 0, 0, 0);
            finish_cycle();
        end
        flush_v = 1'b1;
        drive(1, 4'hf, 4'b0001, 0, 0, 0, 0);
        check("flush_we", 32'(we), 32'd0);
        finish_cycle();
        flush_v = 1'b0;
        drive(1, 4'hf, 4'h0, 0, 0, 0, 0);
        check("flush_cnt", 32'(free_cnt), 32'd8);
        check("flush_waddr", 32'(waddr), 32'h01);
        finish_cycle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imm4_alloc.md
# imm4_alloc

Slot allocator and write-port driver for the 4-wide immediate store. Each cycle it grants one free group of four slots to the dispatch bundle and drives the store's group-write enable and one-hot group select. It tracks per-slot occupancy and frees slots as the issue stage releases them after reading their immediates. Sits between decode/dispatch and the 4-read/4-write immediate store.

## Interface
- WIDTH_ADDR, 5, slot address width; SIZE = 2**WIDTH_ADDR slots, GROUPS = SIZE/4; WIDTH_ADDR >= 3
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_alloc_req  in  1  dispatch bundle requests a group
- i_alloc_mask  in  4  lanes of the bundle carrying an immediate (lane n -> slot 4*g+n)
- o_alloc_ready  out  1  at least one free group exists (registered state)
- o_we  out  1  store write enable = i_alloc_req & o_alloc_ready & |i_alloc_mask
- o_waddr  out  GROUPS  one-hot group select to store; all-zero when o_we=0
- o_gaddr  out  WIDTH_ADDR-2  binary index of granted group; dispatch forms slot tag {o_gaddr, lane}
- i_rel_en  in  4  per-read-port release valid
- i_rel_addr0..i_rel_addr3  in  WIDTH_ADDR each  slot released by read port n
- o_free_cnt  out  WIDTH_ADDR-1  number of fully free groups, 0..GROUPS
- i_flush  in  1  only when IMM4_ALLOC_FLUSH_EN defined

## Operation
- State: busy[SIZE], one bit per slot. Group g is free when busy[4g+3:4g] == 0.
- Grant: lowest-index free group, combinational from registered busy. o_waddr/o_gaddr valid whenever o_we=1; o_gaddr is don't-care otherwise and is driven 0.
- On edge with o_we=1: busy[4g+n] <= 1 for each n with i_alloc_mask[n]=1. Unmasked lanes stay 0, so the group frees once its masked lanes are released.
- i_alloc_req with i_alloc_mask=0: no grant, o_we=0, no state change.
- Release: for each port n with i_rel_en[n]=1, busy[i_rel_addrn] <= 0 on the edge.
- Release of an already-free slot: ignored, no error. Duplicate addresses across ports in one cycle: single clear.
- Simultaneous alloc and release: no conflict possible, since the granted group has no busy bits. Apply both.
- o_free_cnt and o_alloc_ready: registered, recomputed from next-state busy; o_alloc_ready = (o_free_cnt != 0).
- Full: o_alloc_ready=0, o_we=0 regardless of i_alloc_req; dispatch stalls.

## Timing
- Reset (i_rst=1 at edge): busy all 0; o_free_cnt=GROUPS; o_alloc_ready=1; o_we=0 and o_waddr=0 unless a request is present in the cycle after reset.
- Grant latency 0: o_we/o_waddr in same cycle as i_alloc_req; store writes on the same edge that sets busy.
- A group whose last slot is released at edge k is grantable in cycle k+1, not in cycle k.
- o_free_cnt reflects all allocs/releases one cycle after the edge.
- Reset mid-operation discards all occupancy; pending releases that cycle are ignored.

## Configuration
- IMM4_ALLOC_FLUSH_EN defined: i_flush port exists. i_flush=1 at an edge clears all busy bits, sets o_free_cnt=GROUPS, and blocks o_we that cycle (o_we=0). It has priority over alloc and release. Used on branch mispredict.
- Not defined: no i_flush port; occupancy is cleared only by releases or i_rst.

## Structure
- Shared package: localparams SIZE, GROUPS, group-index width WIDTH_ADDR-2, count width WIDTH_ADDR-1; slot-tag field split (group, lane).
- One sub-module: imm4_alloc_pick, a lowest-set-bit priority encoder over the GROUPS free vector producing the one-hot grant, binary index, and any-free flag.

## Test plan
- Reset, then request mask=4'b1111 each cycle for 8 cycles (WIDTH_ADDR=5) -> o_waddr 0x01,0x02,...,0x80; o_gaddr 0..7; after 8th edge o_free_cnt=0, o_alloc_ready=0; 9th request gives o_we=0.
- Full store; release slots 12,13,14,15 on ports 0..3 in one cycle -> next cycle o_free_cnt=1, request grants o_waddr=0x08.
- Alloc group 0 with mask=4'b0101; release slot 0 -> group still busy (o_free_cnt=7); release slot 2 -> o_free_cnt=8.
- Same cycle: alloc request (group 1 free) plus release of slot 0 (last busy in group 0) -> grant is group 1; group 0 grantable next cycle.
- Release of free slot 9 and the same slot 4 on two ports -> no underflow; o_free_cnt correct.
- With IMM4_ALLOC_FLUSH_EN: 5 groups busy, i_flush=1 together with i_alloc_req -> o_we=0; next cycle o_free_cnt=8; request grants o_waddr=0x01.
